sram_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port sram block (8-bit address, 16-bit data).
- Accepts read/write commands from requesters 0 and 1 over valid/ready, with round-robin arbitration.
- Drives the sram write_en/read_en/addr/write_data pins one command at a time.
- Returns read data to the winning requester with a one-cycle response pulse.

---
 rtl/sram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-requester valid/ready arbiter and sequencer in front of a single-port SRAM.
// Round-robin by default; define SRAM_ARB_FIXED_PRIO_EN to make requester 0 win every tie.

module sram_arbiter_rsp #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_cap,
  input  logic [DW-1:0] i_rdata,
  output logic          o_valid,
  output logic [DW-1:0] o_rdata
);
  logic          r_valid;
  logic [DW-1:0] r_rdata;

  // Read data is captured on the edge that ends WAIT, so the pulse lands exactly in RESP
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_valid <= i_cap;
      if (i_cap) r_rdata <= i_rdata;
    end
  end

  assign o_valid = r_valid;
  assign o_rdata = r_rdata;
endmodule

module sram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t r_state, w_next;

  logic          r_win;
  logic          r_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_we;
  logic          r_mem_re;

  logic          w_win1;
  logic          w_accept;
  logic          w_acc_we;
  logic [AW-1:0] w_acc_addr;
  logic [DW-1:0] w_acc_wdata;

  logic [NUM_REQ-1:0]         w_rsp_valid;
  logic [NUM_REQ-1:0][DW-1:0] w_rsp_rdata;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Requester 1 only wins when requester 0 is not asking
  assign w_win1 = ~req0_valid;
`else
  logic r_last_grant;

  // A lone requester wins; on a tie the one not granted last time wins
  assign w_win1 = req0_valid ? (req1_valid & ~r_last_grant) : 1'b1;

  always_ff @(posedge clk) begin
    if (!reset)        r_last_grant <= 1'b1;
    else if (w_accept) r_last_grant <= w_win1;
  end
`endif

  assign w_accept    = (r_state == IDLE) & reset & (req0_valid | req1_valid);
  assign req0_ready  = w_accept & ~w_win1;
  assign req1_ready  = w_accept &  w_win1;
  assign w_acc_we    = w_win1 ? req1_we    : req0_we;
  assign w_acc_addr  = w_win1 ? req1_addr  : req0_addr;
  assign w_acc_wdata = w_win1 ? req1_wdata : req0_wdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ISSUE;
      ISSUE:   w_next = r_we ? IDLE : WAIT;
      WAIT:    w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Memory pins are loaded on the accept edge so they are already registered during ISSUE
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_win       <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      if (w_accept) begin
        r_win       <= w_win1;
        r_we        <= w_acc_we;
        r_mem_addr  <= w_acc_addr;
        r_mem_wdata <= w_acc_wdata;
        r_mem_we    <= w_acc_we;
        r_mem_re    <= ~w_acc_we;
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    sram_arbiter_rsp #(.DW(DW)) u_rsp (
      .clk     (clk),
      .reset   (reset),
      .i_cap   ((r_state == WAIT) && (r_win == (g == 1))),
      .i_rdata (mem_rdata),
      .o_valid (w_rsp_valid[g]),
      .o_rdata (w_rsp_rdata[g])
    );
  end

  assign rsp0_valid = w_rsp_valid[0];
  assign rsp0_rdata = w_rsp_rdata[0];
  assign rsp1_valid = w_rsp_valid[1];
  assign rsp1_rdata = w_rsp_rdata[1];
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a transaction-level model predicts grants, SRAM pulses and read responses.
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [7:0]  req0_addr = '0;
  logic [15:0] req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [7:0]  req1_addr = '0;
  logic [15:0] req1_wdata = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_rdata, rsp1_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  sram_arbiter #(.AW(8), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM the DUT drives: write on the edge, read data appears for the following cycle
  bit [15:0] sram [256];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sram[mem_addr];
  end

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  bit rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge <= !reset;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { bit we; logic [7:0] a; logic [15:0] d; int cyc; } mexp_t;
  typedef struct { logic [15:0] d; int cyc; } rexp_t;
  mexp_t q_mem[$];
  rexp_t q_rsp0[$], q_rsp1[$];

  // Reference model: commands serialize, so a read returns whatever the last accepted write left
  bit [15:0] ref_mem [256];
  int m_busy = 0;
  bit m_last = 1'b1;

  always @(negedge clk) begin
    mexp_t me; rexp_t re; bit w, e0, e1, a_we; logic [7:0] a; logic [15:0] d;
    if (rst_at_edge)
      chk("reset_outs", {mem_addr, mem_wdata, mem_we, mem_re, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata}, 64'd0);
    if (mem_we || mem_re) begin
      if (q_mem.size() == 0) chk("mem_unexpected", {mem_we, mem_re}, 2'b00);
      else begin
        me = q_mem.pop_front();
        chk("mem_we", mem_we, me.we);
        chk("mem_re", mem_re, !me.we);
        chk("mem_addr", mem_addr, me.a);
        if (me.we) chk("mem_wdata", mem_wdata, me.d);
        chk("mem_cycle", cyc, me.cyc);
      end
    end
    if (rsp0_valid) begin
      if (q_rsp0.size() == 0) chk("rsp0_unexpected", rsp0_valid, 1'b0);
      else begin
        re = q_rsp0.pop_front();
        chk("rsp0_rdata", rsp0_rdata, re.d);
        chk("rsp0_cycle", cyc, re.cyc);
      end
    end
    if (rsp1_valid) begin
      if (q_rsp1.size() == 0) chk("rsp1_unexpected", rsp1_valid, 1'b0);
      else begin
        re = q_rsp1.pop_front();
        chk("rsp1_rdata", rsp1_rdata, re.d);
        chk("rsp1_cycle", cyc, re.cyc);
      end
    end
    if (!reset) begin
      chk("ready0_in_reset", req0_ready, 1'b0);
      chk("ready1_in_reset", req1_ready, 1'b0);
      q_mem.delete(); q_rsp0.delete(); q_rsp1.delete();
      m_busy = 0; m_last = 1'b1;
    end else begin
      e0 = 1'b0; e1 = 1'b0; w = 1'b0;
      if (m_busy > 0) m_busy--;
      else if (req0_valid || req1_valid) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        w = !req0_valid;
`else
        if (req0_valid && req1_valid) w = !m_last;
        else                          w = req1_valid;
`endif
        e0 = !w; e1 = w;
      end
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      if (e0 || e1) begin
        a_we = w ? req1_we : req0_we;
        a    = w ? req1_addr : req0_addr;
        d    = w ? req1_wdata : req0_wdata;
        m_last = w;
        q_mem.push_back('{we: a_we, a: a, d: d, cyc: cyc + 1});
        if (a_we) begin
          ref_mem[a] = d;
          m_busy = 1;
        end else begin
          m_busy = 3;
          if (w) q_rsp1.push_back('{d: ref_mem[a], cyc: cyc + 3});
          else   q_rsp0.push_back('{d: ref_mem[a], cyc: cyc + 3});
        end
      end
    end
  end

  task automatic set_req(input int r, input bit v, input bit we, input logic [7:0] a, input logic [15:0] d);
    if (r == 0) begin req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; end
    else        begin req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // hold == 0: keep valid until accepted (bounded); hold > 0: withdraw after that many cycles
  task automatic send(input int r, input bit we, input logic [7:0] a, input logic [15:0] d, input int hold);
    int lim; bit acc;
    lim = (hold == 0) ? 64 : hold;
    acc = 1'b0;
    set_req(r, 1'b1, we, a, d);
    for (int i = 0; i < lim && !acc; i++) begin
      @(negedge clk);
      acc = (r == 0) ? req0_ready : req1_ready;
      @(posedge clk); #1;
    end
    set_req(r, 1'b0, we, a, d);
    if (hold == 0) chk($sformatf("accept_r%0d", r), acc, 1'b1);
  endtask

  task automatic rnd(input int r, input int n);
    bit we; logic [7:0] a; int hold, pick;
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 9);
      a = (pick == 0) ? 8'hFF : (pick == 1) ? 8'h00 : 8'($urandom_range(0, 7));
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      send(r, we, a, 16'($urandom), hold);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    req0_valid = 1'b1;
    tick(3);
    reset = 1'b1;
    req0_valid = 1'b0;
    tick(1);

    // Single write then read from requester 0
    send(0, 1'b1, 8'h05, 16'hABCD, 0);
    send(0, 1'b0, 8'h05, 16'h0000, 0);
    tick(4);
    send(0, 1'b1, 8'h0A, 16'h1234, 0);
    tick(2);

    // Simultaneous reads right after reset: requester 0 wins the first tie
    reset = 1'b0; tick(2); reset = 1'b1;
    fork
      send(0, 1'b0, 8'h0A, 16'h0, 0);
      send(1, 1'b0, 8'h05, 16'h0, 0);
    join
    tick(5);

    // Fairness: both continuously valid with writes
    fork
      for (int i = 0; i < 4; i++) send(0, 1'b1, 8'(8'h20 + i), 16'(16'h1000 + i), 0);
      for (int i = 0; i < 4; i++) send(1, 1'b1, 8'(8'h30 + i), 16'(16'h2000 + i), 0);
    join
    tick(2);

    // Address and data extremes
    send(0, 1'b1, 8'hFF, 16'hFFFF, 0);
    send(1, 1'b1, 8'h00, 16'h0001, 0);
    send(0, 1'b0, 8'hFF, 16'h0, 0);
    send(1, 1'b0, 8'h00, 16'h0, 0);
    tick(5);

    // Reset during WAIT drops the read; a fresh read afterwards completes
    send(0, 1'b0, 8'h05, 16'h0, 0);
    tick(1);
    reset = 1'b0; tick(2); reset = 1'b1;
    send(1, 1'b0, 8'hFF, 16'h0, 0);
    tick(5);

    // Requester 1 pulses valid only while requester 0 is being serviced
    send(0, 1'b0, 8'h0A, 16'h0, 0);
    set_req(1, 1'b1, 1'b1, 8'h33, 16'h5555);
    tick(1);
    set_req(1, 1'b0, 1'b1, 8'h33, 16'h5555);
    tick(5);

    fork
      rnd(0, 40);
      rnd(1, 40);
    join
    tick(10);

    chk("mem_queue_drained", q_mem.size(), 0);
    chk("rsp0_queue_drained", q_rsp0.size(), 0);
    chk("rsp1_queue_drained", q_rsp1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
